// File: rtl/vd_loopback_tester.sv
// Self-checking traffic generator/checker for the encoder/Viterbi loop-back path.
// Sends NUM_FRAMES words, keeps them in a small FIFO and scores the returned words.
module vd_loopback_tester #(
  parameter int                   SIZE_DATA  = 8,
  parameter int                   NUM_FRAMES = 16,
  parameter int                   FIFO_DEPTH = 4,
  parameter logic [SIZE_DATA-1:0] LFSR_TAPS  = SIZE_DATA'(8'hB8),
  parameter int                   TIMEOUT    = 1_000_000,
  parameter int                   CNT_W      = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic                 i_mode,
  input  logic [SIZE_DATA-1:0] i_seed,
  output logic [SIZE_DATA-1:0] o_tx_data,
  output logic                 o_tx_valid,
  input  logic                 i_tx_ready,
  input  logic [SIZE_DATA-1:0] i_rx_data,
  input  logic                 i_rx_valid,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_pass,
  output logic                 o_timeout,
  output logic                 o_sync_err,
  output logic [CNT_W-1:0]     o_frame_err,
  output logic [CNT_W-1:0]     o_bit_err
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int SENT_W = $clog2(NUM_FRAMES + 1);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam int POP_W  = $clog2(SIZE_DATA + 1);

  localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(FIFO_DEPTH);
  localparam logic [SENT_W-1:0] FRAMES    = SENT_W'(NUM_FRAMES);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t r_state;
  state_t w_state_next;

  logic [SIZE_DATA-1:0] r_gen;
  logic                 r_mode;
  logic [SIZE_DATA-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [FCNT_W-1:0]    r_fcnt;
  logic [SENT_W-1:0]    r_sent;
  logic [SENT_W-1:0]    r_recv;
  logic [IDLE_W-1:0]    r_idle;
  logic [CNT_W-1:0]     r_frame_err;
  logic [CNT_W-1:0]     r_bit_err;
  logic                 r_timeout;
  logic                 r_sync_err;

  logic                 w_start;
  logic                 w_active;
  logic                 w_push;
  logic                 w_rx;
  logic                 w_pop;
  logic                 w_sync;
  logic                 w_timeout_hit;
  logic [SIZE_DATA-1:0] w_gen_adv;
  logic [SIZE_DATA-1:0] w_seed_load;
  logic [SIZE_DATA-1:0] w_diff;
  logic [POP_W-1:0]     w_popcnt;
  logic [CNT_W:0]       w_bit_sum;

  assign w_start  = i_start && !i_abort && (r_state == S_IDLE || r_state == S_DONE);
  assign w_active = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_push   = o_tx_valid && i_tx_ready && !i_abort;
  assign w_rx     = i_rx_valid && w_active && !i_abort;
  // No bypass: a strobe against an empty FIFO is a sync error even if a push lands this cycle.
  assign w_pop    = w_rx && (r_fcnt != '0);
  assign w_sync   = w_rx && (r_fcnt == '0);
  assign w_timeout_hit = (r_state == S_DRAIN) && (r_recv != FRAMES) && (r_idle == IDLE_MAX);

  assign w_seed_load = (i_mode && i_seed == '0) ? SIZE_DATA'(1) : i_seed;
  assign w_diff      = r_mem[r_rd_ptr] ^ i_rx_data;

  always_comb begin
    w_gen_adv = r_gen + SIZE_DATA'(1);
    if (r_mode) begin
      w_gen_adv = (r_gen >> 1) ^ (r_gen[0] ? LFSR_TAPS : '0);
    end
  end

  always_comb begin
    w_popcnt = '0;
    for (int k = 0; k < SIZE_DATA; k++) begin
      w_popcnt = w_popcnt + POP_W'(w_diff[k]);
    end
    w_bit_sum = {1'b0, r_bit_err} + (CNT_W + 1)'(w_popcnt);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    o_busy       = w_active;
    o_done       = (r_state == S_DONE);
    o_tx_valid   = (r_state == S_RUN) && (r_sent != FRAMES) && (r_fcnt != FIFO_FULL);
    if (i_abort) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (i_start) w_state_next = S_RUN;
        S_RUN:   if (r_sent == FRAMES) w_state_next = S_DRAIN;
        S_DRAIN: begin
          if (r_recv == FRAMES)   w_state_next = S_DONE;
          else if (w_timeout_hit) w_state_next = S_DONE;
        end
        S_DONE:  if (i_start) w_state_next = S_RUN;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // Storage has no reset so it maps onto distributed RAM; occupancy lives in r_fcnt.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= r_gen;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_gen       <= '0;
      r_mode      <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_fcnt      <= '0;
      r_sent      <= '0;
      r_recv      <= '0;
      r_idle      <= '0;
      r_frame_err <= '0;
      r_bit_err   <= '0;
      r_timeout   <= 1'b0;
      r_sync_err  <= 1'b0;
    end else if (i_abort) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fcnt   <= '0;
      r_idle   <= '0;
    end else if (w_start) begin
      r_gen       <= w_seed_load;
      r_mode      <= i_mode;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_fcnt      <= '0;
      r_sent      <= '0;
      r_recv      <= '0;
      r_idle      <= '0;
      r_frame_err <= '0;
      r_bit_err   <= '0;
      r_timeout   <= 1'b0;
      r_sync_err  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        r_gen    <= w_gen_adv;
        r_sent   <= r_sent + SENT_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_recv   <= r_recv + SENT_W'(1);
        if (w_diff != '0 && r_frame_err != CNT_MAX) begin
          r_frame_err <= r_frame_err + CNT_W'(1);
        end
        r_bit_err <= w_bit_sum[CNT_W] ? CNT_MAX : w_bit_sum[CNT_W-1:0];
      end
      if (w_sync) begin
        r_sync_err <= 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_fcnt <= r_fcnt + FCNT_W'(1);
        2'b01:   r_fcnt <= r_fcnt - FCNT_W'(1);
        default: r_fcnt <= r_fcnt;
      endcase
      if (r_state == S_DRAIN) begin
        if (i_rx_valid)            r_idle <= '0;
        else if (r_idle != IDLE_MAX) r_idle <= r_idle + IDLE_W'(1);
      end else begin
        r_idle <= '0;
      end
      if (w_timeout_hit) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign o_tx_data   = r_gen;
  assign o_timeout   = r_timeout;
  assign o_sync_err  = r_sync_err;
  assign o_frame_err = r_frame_err;
  assign o_bit_err   = r_bit_err;
  assign o_pass      = o_done && (r_frame_err == '0) && !r_timeout && !r_sync_err;

endmodule

// File: tb/tb_vd_loopback_tester.sv
// Scoreboard bench for vd_loopback_tester: a loop-back model returns tx words after a delay,
// a monitor checks every sent word and every end-of-run result against queued expectations.
module tb_vd_loopback_tester;

  logic        clk;
  logic        rst_n;
  logic        i_start, i_abort, i_mode;
  logic [7:0]  i_seed;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        o_busy, o_done, o_pass, o_timeout, o_sync_err;
  logic [15:0] o_frame_err, o_bit_err;

  vd_loopback_tester #(
    .SIZE_DATA(8), .NUM_FRAMES(16), .FIFO_DEPTH(4),
    .LFSR_TAPS(8'hB8), .TIMEOUT(40), .CNT_W(16)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_abort(i_abort),
    .i_mode(i_mode), .i_seed(i_seed), .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid),
    .i_tx_ready(i_tx_ready), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass), .o_timeout(o_timeout),
    .o_sync_err(o_sync_err), .o_frame_err(o_frame_err), .o_bit_err(o_bit_err)
  );

  typedef struct {
    logic [15:0] fe;
    logic [15:0] be;
    logic        to;
    logic        se;
    logic        ps;
  } res_t;

  logic [7:0] exp_tx[$];
  res_t       exp_res[$];
  logic [7:0] lb_data[$];
  int         lb_due[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int tx_hs_cnt = 0;
  int lb_idx = 0;
  int drop_idx = -1;
  int corrupt_idx = -1;
  logic [7:0] corrupt_mask = 8'h00;
  logic lb_on = 1'b0;
  logic lb_hold = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] prbs_step(input logic [7:0] s);
    return {1'b0, s[7:1]} ^ (s[0] ? 8'hB8 : 8'h00);
  endfunction

  task automatic setup_run(input int drop, input int cidx, input logic [7:0] cmask);
    exp_tx.delete();
    exp_res.delete();
    lb_data.delete();
    lb_due.delete();
    lb_idx       = 0;
    drop_idx     = drop;
    corrupt_idx  = cidx;
    corrupt_mask = cmask;
  endtask

  task automatic push_counter(input logic [7:0] seed);
    logic [7:0] w;
    w = seed;
    for (int i = 0; i < 16; i++) begin
      exp_tx.push_back(w);
      w = w + 8'd1;
    end
  endtask

  task automatic expect_res(input logic [15:0] fe, input logic [15:0] be,
                            input logic to, input logic se, input logic ps);
    res_t r;
    r.fe = fe; r.be = be; r.to = to; r.se = se; r.ps = ps;
    exp_res.push_back(r);
  endtask

  task automatic start_run(input logic mode, input logic [7:0] seed);
    i_mode  = mode;
    i_seed  = seed;
    i_start = 1'b1;
    tick(1);
    i_start = 1'b0;
  endtask

  task automatic pulse_abort();
    i_abort = 1'b1;
    tick(1);
    i_abort = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k;
    k = 0;
    while (!o_done && k < budget) begin
      tick(1);
      k++;
    end
    if (!o_done) begin
      n_checks++;
      $display("FAIL %s: o_done not seen within %0d cycles", name, budget);
    end else begin
      @(negedge clk);
      tick(1);
      check({name, "_all_sent"}, exp_tx.size(), 0);
    end
  endtask

  // Loop-back model: each accepted tx word comes back on rx five cycles later.
  initial begin
    logic [7:0] d;
    forever begin
      @(negedge clk);
      cyc++;
      if (lb_on) begin
        if (rst_n && o_tx_valid && i_tx_ready) begin
          lb_data.push_back(o_tx_data);
          lb_due.push_back(cyc + 5);
        end
        i_rx_valid = 1'b0;
        if (!lb_hold && lb_data.size() > 0 && lb_due[0] <= cyc) begin
          d = lb_data.pop_front();
          void'(lb_due.pop_front());
          if (lb_idx != drop_idx) begin
            i_rx_data  = (lb_idx == corrupt_idx) ? (d ^ corrupt_mask) : d;
            i_rx_valid = 1'b1;
          end
          lb_idx++;
        end
      end
    end
  end

  // Monitor: checks every accepted tx word and every run result.
  initial begin
    logic done_prev;
    logic [7:0] e;
    res_t r;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && o_tx_valid && i_tx_ready) begin
        tx_hs_cnt++;
        $display("tx word %02h", o_tx_data);
        if (exp_tx.size() == 0) begin
          n_checks++;
          $display("FAIL tx_unexpected: got word %02h, expected no transfer", o_tx_data);
        end else begin
          e = exp_tx.pop_front();
          check("tx_word", o_tx_data, e);
        end
      end
      if (o_done && !done_prev) begin
        $display("run done: frame_err=%0d bit_err=%0d timeout=%0b sync=%0b pass=%0b",
                 o_frame_err, o_bit_err, o_timeout, o_sync_err, o_pass);
        if (exp_res.size() == 0) begin
          n_checks++;
          $display("FAIL done_unexpected: got o_done=1, expected no completion");
        end else begin
          r = exp_res.pop_front();
          check("res_frame_err", o_frame_err, r.fe);
          check("res_bit_err",   o_bit_err,   r.be);
          check("res_timeout",   o_timeout,   r.to);
          check("res_sync_err",  o_sync_err,  r.se);
          check("res_pass",      o_pass,      r.ps);
        end
      end
      done_prev = o_done;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_all_zero(input string name);
    check({name, "_tx_data"},   o_tx_data,   0);
    check({name, "_tx_valid"},  o_tx_valid,  0);
    check({name, "_busy"},      o_busy,      0);
    check({name, "_done"},      o_done,      0);
    check({name, "_pass"},      o_pass,      0);
    check({name, "_timeout"},   o_timeout,   0);
    check({name, "_sync_err"},  o_sync_err,  0);
    check({name, "_frame_err"}, o_frame_err, 0);
    check({name, "_bit_err"},   o_bit_err,   0);
  endtask

  initial begin
    int k;
    logic [7:0] w;
    rst_n = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_mode = 1'b0; i_seed = 8'h00;
    i_tx_ready = 1'b1; i_rx_data = 8'h00; i_rx_valid = 1'b0;
    tick(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    tick(2);

    // Counter mode, clean loop-back.
    setup_run(-1, -1, 8'h00);
    push_counter(8'h10);
    expect_res(16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
    lb_on = 1'b1;
    start_run(1'b0, 8'h10);
    wait_done("counter", 300);

    // PRBS mode, seed 0 replaced by 1.
    setup_run(-1, -1, 8'h00);
    exp_tx.push_back(8'h01);
    exp_tx.push_back(8'hB8);
    exp_tx.push_back(8'h5C);
    w = 8'h5C;
    for (int i = 3; i < 16; i++) begin
      w = prbs_step(w);
      exp_tx.push_back(w);
    end
    expect_res(16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
    start_run(1'b1, 8'h00);
    wait_done("prbs", 300);

    // Frame 3 comes back with bits 0 and 7 flipped.
    setup_run(-1, 3, 8'h81);
    push_counter(8'h20);
    expect_res(16'd1, 16'd2, 1'b0, 1'b0, 1'b0);
    start_run(1'b0, 8'h20);
    wait_done("corrupt", 300);

    // Withheld rx: FIFO fills to 4, then ready-low stall keeps data stable.
    setup_run(-1, -1, 8'h00);
    push_counter(8'h30);
    expect_res(16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
    lb_hold = 1'b1;
    tx_hs_cnt = 0;
    start_run(1'b0, 8'h30);
    tick(12);
    check("full_accepted", tx_hs_cnt, 4);
    check("full_tx_valid", o_tx_valid, 0);
    i_tx_ready = 1'b0;
    lb_hold = 1'b0;
    tick(8);
    check("stall_tx_valid", o_tx_valid, 1);
    check("stall_tx_data_a", o_tx_data, 8'h34);
    tick(4);
    check("stall_tx_data_b", o_tx_data, 8'h34);
    check("stall_accepted", tx_hs_cnt, 4);
    i_tx_ready = 1'b1;
    wait_done("stall", 300);

    // Last frame never returns: timeout.
    setup_run(15, -1, 8'h00);
    push_counter(8'h50);
    expect_res(16'd0, 16'd0, 1'b1, 1'b0, 1'b0);
    start_run(1'b0, 8'h50);
    wait_done("timeout", 400);

    // rx strobe in IDLE is ignored; flags hold across abort.
    pulse_abort();
    check("idle_done", o_done, 0);
    lb_on = 1'b0;
    i_rx_valid = 1'b0;
    tick(1);
    i_rx_data = 8'hAA;
    i_rx_valid = 1'b1;
    tick(1);
    i_rx_valid = 1'b0;
    tick(1);
    check("idle_rx_sync", o_sync_err, 0);
    check("idle_rx_frame", o_frame_err, 0);
    check("abort_timeout_held", o_timeout, 1);

    // rx strobe in RUN with the FIFO empty sets the sticky sync error.
    setup_run(-1, -1, 8'h00);
    push_counter(8'h60);
    expect_res(16'd0, 16'd0, 1'b0, 1'b1, 1'b0);
    i_tx_ready = 1'b0;
    start_run(1'b0, 8'h60);
    i_rx_data = 8'h60;
    i_rx_valid = 1'b1;
    tick(1);
    i_rx_valid = 1'b0;
    tick(1);
    check("sync_set", o_sync_err, 1);
    check("sync_frame", o_frame_err, 0);
    check("sync_bit", o_bit_err, 0);
    check("sync_timeout_clr", o_timeout, 0);
    lb_on = 1'b1;
    i_tx_ready = 1'b1;
    wait_done("sync", 300);

    // Asynchronous reset in the middle of a run.
    setup_run(-1, 0, 8'h01);
    push_counter(8'h70);
    start_run(1'b0, 8'h70);
    tick(12);
    check("pre_rst_frame", o_frame_err, 1);
    check("pre_rst_bit", o_bit_err, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrun_rst");
    tick(2);
    rst_n = 1'b1;
    setup_run(-1, -1, 8'h00);
    tick(2);

    // Abort while draining: error counters hold.
    setup_run(15, 1, 8'h03);
    push_counter(8'h40);
    start_run(1'b0, 8'h40);
    k = 0;
    while (exp_tx.size() != 0 && k < 300) begin
      tick(1);
      k++;
    end
    check("drain_words_left", exp_tx.size(), 0);
    tick(15);
    check("drain_busy", o_busy, 1);
    check("drain_done", o_done, 0);
    pulse_abort();
    check("abort_busy", o_busy, 0);
    check("abort_done", o_done, 0);
    check("abort_frame_held", o_frame_err, 1);
    check("abort_bit_held", o_bit_err, 2);
    check("abort_timeout", o_timeout, 0);

    // Clean restart with counter wrap-around.
    setup_run(-1, -1, 8'h00);
    push_counter(8'hF8);
    expect_res(16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
    start_run(1'b0, 8'hF8);
    check("restart_frame_clr", o_frame_err, 0);
    check("restart_bit_clr", o_bit_err, 0);
    check("restart_busy", o_busy, 1);
    wait_done("restart", 300);

    check("results_left", exp_res.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
